// File: rtl/inst_prefetch.sv
// Instruction prefetch: pipelined Wishbone reads into a {pc, data} FIFO, flushed on redirect.
// States: RUN = fetching and buffering | DRAIN = dropping acks of reads issued before a redirect.
module inst_prefetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              inst_ready_i,
  output logic              inst_cyc_o,
  output logic              inst_stb_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [DATA_W-1:0] inst_data_i,
  input  logic              inst_stall_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic              stb_q, stb_d;
  logic              cyc_q, cyc_d;
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];

  logic              accept, ack_run, ack_drop, pop;
  logic [ADDR_W-1:0] head_pc;
  logic [CW:0]       load_d;

  always_comb begin
    accept   = stb_q & ~inst_stall_i;
    ack_run  = inst_ack_i & (state_q == ST_RUN) & (out_q != '0);
    ack_drop = inst_ack_i & (state_q == ST_DRAIN) & (disc_q != '0);
    pop      = (cnt_q != '0) & inst_ready_i;
    // Outstanding reads are always the last out_q sequential addresses, so the
    // oldest one's pc falls out of fetch_pc without storing a separate queue.
    head_pc  = fetch_pc_q - ADDR_W'(out_q);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    mem_pc_d   = mem_pc_q;
    mem_data_d = mem_data_q;

    if (redirect_i) begin
      disc_d     = disc_q + out_q + CW'(accept) - CW'(ack_run) - CW'(ack_drop);
      out_d      = '0;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      fetch_pc_d = redirect_pc_i;
      state_d    = (disc_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (state_q == ST_RUN) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(accept);
        out_d      = out_q + CW'(accept) - CW'(ack_run);
        if (ack_run) begin
          mem_pc_d[wr_q]   = head_pc;
          mem_data_d[wr_q] = inst_data_i;
          wr_d             = wr_q + PW'(1);
        end
      end else begin
        disc_d = disc_q - CW'(ack_drop);
        if (disc_d == '0) state_d = ST_RUN;
      end
      cnt_d = cnt_q + CW'(ack_run) - CW'(pop);
      if (pop) rd_d = rd_q + PW'(1);
    end

    load_d = {1'b0, cnt_d} + {1'b0, out_d};
    stb_d  = (state_d == ST_RUN) && (load_d < (CW+1)'(DEPTH));
    cyc_d  = stb_d | (out_d != '0) | (disc_d != '0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      mem_pc_q   <= mem_pc_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign inst_valid_o = (cnt_q != '0);
  assign inst_pc_o    = mem_pc_q[rd_q];
  assign inst_data_o  = mem_data_q[rd_q];
  assign inst_stb_o   = stb_q;
  assign inst_cyc_o   = cyc_q;
  assign inst_addr_o  = fetch_pc_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: fixed-latency pipelined slave model and a core that logs pops.
module tb_inst_prefetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [15:0] inst_pc_o;
  logic [31:0] inst_data_o;
  logic        inst_ready_i = 1'b0;
  logic        inst_cyc_o;
  logic        inst_stb_o;
  logic [15:0] inst_addr_o;
  logic        inst_ack_i = 1'b0;
  logic [31:0] inst_data_i = '0;
  logic        inst_stall_i = 1'b0;

  inst_prefetch dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_pc_o     (inst_pc_o),
    .inst_data_o   (inst_data_o),
    .inst_ready_i  (inst_ready_i),
    .inst_cyc_o    (inst_cyc_o),
    .inst_stb_o    (inst_stb_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ack_i    (inst_ack_i),
    .inst_data_i   (inst_data_i),
    .inst_stall_i  (inst_stall_i)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int lat = 1;
  int n_acc = 0;
  logic [15:0] sq_addr[$];
  int          sq_due[$];
  logic [15:0] dq_pc[$];
  logic [31:0] dq_data[$];
  int          dq_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] wdat(input logic [15:0] a);
    return {16'h0000, a} ^ 32'hA5A50000;
  endfunction

  task automatic drive_slave();
    if (sq_addr.size() > 0 && sq_due[0] <= cyc_n + 1) begin
      inst_ack_i  = 1'b1;
      inst_data_i = wdat(sq_addr[0]);
    end else begin
      inst_ack_i  = 1'b0;
      inst_data_i = '0;
    end
  endtask

  task automatic clear_logs();
    sq_addr.delete(); sq_due.delete();
    dq_pc.delete(); dq_data.delete(); dq_cyc.delete();
    n_acc = 0;
  endtask

  task automatic step();
    logic acc, ackc, popc;
    logic [15:0] a, p;
    logic [31:0] d;
    acc  = inst_stb_o & ~inst_stall_i;
    ackc = inst_ack_i;
    popc = inst_valid_o & inst_ready_i;
    a = inst_addr_o; p = inst_pc_o; d = inst_data_o;
    @(posedge sys_clk); #1;
    cyc_n++;
    if (popc) begin
      dq_pc.push_back(p); dq_data.push_back(d); dq_cyc.push_back(cyc_n);
    end
    if (ackc && sq_addr.size() > 0) begin
      void'(sq_addr.pop_front()); void'(sq_due.pop_front());
    end
    if (acc) begin
      sq_addr.push_back(a); sq_due.push_back(cyc_n + lat); n_acc++;
    end
    drive_slave();
  endtask

  task automatic do_reset(input logic rdy, input int l);
    sys_rst = 1'b0;
    redirect_i = 1'b0; inst_stall_i = 1'b0; inst_ack_i = 1'b0; inst_data_i = '0;
    inst_ready_i = rdy; lat = l;
    clear_logs();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  task automatic check_reset_outs(input string pfx);
    chk({pfx, "_cyc"},   32'(inst_cyc_o), 32'd0);
    chk({pfx, "_stb"},   32'(inst_stb_o), 32'd0);
    chk({pfx, "_addr"},  32'(inst_addr_o), 32'h0000);
    chk({pfx, "_valid"}, 32'(inst_valid_o), 32'd0);
    chk({pfx, "_pc"},    32'(inst_pc_o), 32'd0);
    chk({pfx, "_data"},  inst_data_o, 32'd0);
  endtask

  task automatic wait_deliv(input string tag, input int n, input int budget);
    int k = 0;
    while (dq_pc.size() < n && k < budget) begin step(); k++; end
    chk(tag, 32'(dq_pc.size() >= n), 32'd1);
  endtask

  task automatic seq_check(input string tag, input logic [15:0] base, input int n);
    int bad = 0;
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      e = base + 16'(i);
      if (i >= dq_pc.size()) bad++;
      else if (dq_pc[i] !== e || dq_data[i] !== wdat(e)) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, k, n, vbad, nacc0, bad;

    #1;
    check_reset_outs("rst");

    // Sequential fetch, one-cycle slave, core always ready
    do_reset(1'b1, 1);
    step();
    chk("t1_stb_first", 32'(inst_stb_o), 32'd1);
    chk("t1_addr_first", 32'(inst_addr_o), 32'h0000);
    cnt = 0;
    repeat (20) begin step(); if (!inst_cyc_o) cnt++; end
    chk("t1_cyc_hold", 32'(cnt), 32'd0);
    seq_check("t1_seq", 16'h0000, 8);
    chk("t1_rate", (dq_cyc.size() >= 8) ? 32'(dq_cyc[7] - dq_cyc[0]) : 32'hFFFFFFFF, 32'd7);

    // Core stalled: credit limit caps issue at 4
    do_reset(1'b0, 1);
    repeat (20) step();
    chk("t2_nreq", 32'(n_acc), 32'd4);
    chk("t2_stb_off", 32'(inst_stb_o), 32'd0);
    chk("t2_valid", 32'(inst_valid_o), 32'd1);
    chk("t2_head_pc", 32'(inst_pc_o), 32'h0000);
    inst_ready_i = 1'b1;
    wait_deliv("t2_deliv", 6, 30);
    seq_check("t2_seq", 16'h0000, 6);
    chk("t2_burst", (dq_cyc.size() >= 4) ? 32'(dq_cyc[3] - dq_cyc[0]) : 32'hFFFFFFFF, 32'd3);

    // Bus stall with pc 5 on the bus
    do_reset(1'b1, 1);
    k = 0;
    while (!(inst_stb_o && inst_addr_o == 16'h0005) && k < 20) begin step(); k++; end
    chk("t3_reach", 32'(inst_addr_o), 32'h0005);
    inst_stall_i = 1'b1;
    nacc0 = n_acc; bad = 0;
    repeat (5) begin step(); if (inst_addr_o != 16'h0005 || !inst_stb_o) bad++; end
    chk("t3_hold", 32'(bad), 32'd0);
    chk("t3_noacc", 32'(n_acc - nacc0), 32'd0);
    inst_stall_i = 1'b0;
    repeat (12) step();
    cnt = 0;
    foreach (dq_pc[i]) if (dq_pc[i] == 16'h0005) cnt++;
    chk("t3_once5", 32'(cnt), 32'd1);
    seq_check("t3_seq", 16'h0000, 8);

    // Redirect with 3 reads outstanding on a 3-cycle slave
    do_reset(1'b1, 3);
    k = 0;
    while (sq_addr.size() < 3 && k < 10) begin step(); k++; end
    redirect_i = 1'b1; redirect_pc_i = 16'h0100;
    step();
    redirect_i = 1'b0;
    chk("t4_stb_off", 32'(inst_stb_o), 32'd0);
    n = 0; vbad = 0;
    while (!inst_stb_o && n < 20) begin step(); n++; if (inst_valid_o) vbad++; end
    chk("t4_resume", 32'(n), 32'd3);
    chk("t4_valid_drain", 32'(vbad), 32'd0);
    chk("t4_addr", 32'(inst_addr_o), 32'h0100);
    wait_deliv("t4_deliv", 2, 30);
    chk("t4_first_pc", (dq_pc.size() > 0) ? 32'(dq_pc[0]) : 32'hFFFFFFFF, 32'h0100);
    seq_check("t4_seq", 16'h0100, 2);

    // Redirect coincident with ack and pop
    do_reset(1'b1, 1);
    repeat (8) step();
    chk("t5_pre_valid", 32'(inst_valid_o & inst_ack_i), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 16'h0040;
    step();
    redirect_i = 1'b0;
    dq_pc.delete(); dq_data.delete(); dq_cyc.delete();
    chk("t5_flush", 32'(inst_valid_o), 32'd0);
    wait_deliv("t5_deliv", 4, 30);
    chk("t5_first_pc", (dq_pc.size() > 0) ? 32'(dq_pc[0]) : 32'hFFFFFFFF, 32'h0040);
    seq_check("t5_seq", 16'h0040, 4);

    // Address wrap, then asynchronous reset mid-stream
    do_reset(1'b1, 1);
    repeat (4) step();
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
    step();
    redirect_i = 1'b0;
    dq_pc.delete(); dq_data.delete(); dq_cyc.delete();
    wait_deliv("t6_deliv", 3, 30);
    seq_check("t6_wrap", 16'hFFFF, 3);
    repeat (3) step();
    chk("t6_pre_cyc", 32'(inst_cyc_o), 32'd1);
    #2;
    sys_rst = 1'b0;
    inst_ack_i = 1'b0; inst_data_i = '0;
    #1;
    check_reset_outs("t6_rst");
    clear_logs();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    step();
    chk("t6_stb_restart", 32'(inst_stb_o), 32'd1);
    chk("t6_addr_restart", 32'(inst_addr_o), 32'h0000);
    wait_deliv("t6_deliv2", 1, 20);
    chk("t6_first_pc", (dq_pc.size() > 0) ? 32'(dq_pc[0]) : 32'hFFFFFFFF, 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
